// File: rtl/image_frame_writer.sv
// image_frame_writer: parses a byte stream (sync byte, bank byte, raster-order
// pixels, optional checksum byte) and writes RGB332 pixels into one of two
// banks of the shared image memory.
// Optional feature: define IMAGE_WRITER_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the pixels and report mismatches on frame_err.
module image_frame_writer #(
    parameter int unsigned IMG_W     = 320,
    parameter int unsigned IMG_H     = 240,
    parameter int unsigned BANK_SIZE = 76800,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        abort,
    output logic        wr_en,
    output logic [17:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        bank,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
    localparam logic [17:0]   BANK1_BASE = 18'(BANK_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PIX,
        S_CHK,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [17:0]    addr;
    logic           take;
    logic           last_px;

    assign take    = s_valid && s_ready;
    assign last_px = (x == X_LAST) && (y == Y_LAST);

    // Next-state selection; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (take && (s_data == SYNC_BYTE)) state_nxt = S_HDR;
                S_HDR:  if (take) state_nxt = S_PIX;
                S_PIX: begin
                    if (take && last_px) begin
`ifdef IMAGE_WRITER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
                S_CHK:  if (take) state_nxt = S_DONE;
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, registered handshake/status outputs, and the pixel write path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            bank       <= 1'b0;
            addr       <= '0;
            x          <= '0;
            y          <= '0;
        end else begin
            state      <= state_nxt;
            s_ready    <= (state_nxt != S_DONE);
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_DONE);
            wr_en      <= 1'b0;
            if (take && !abort) begin
                case (state)
                    S_HDR: begin
                        bank <= s_data[0];
                        addr <= s_data[0] ? BANK1_BASE : 18'd0;
                        x    <= '0;
                        y    <= '0;
                    end
                    S_PIX: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= s_data;
                        addr    <= addr + 18'd1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMAGE_WRITER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of pixel bytes, compared against the trailing byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum      <= '0;
            frame_err <= 1'b0;
        end else if (take && !abort) begin
            if (state == S_HDR) begin
                csum      <= '0;
                frame_err <= 1'b0;
            end else if (state == S_PIX) begin
                csum <= csum ^ s_data;
            end else if (state == S_CHK) begin
                frame_err <= (csum != s_data);
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_image_frame_writer.sv
// Self-checking bench for image_frame_writer using a small image geometry.
module tb_image_frame_writer;

    localparam int unsigned IMG_W     = 8;
    localparam int unsigned IMG_H     = 6;
    localparam int unsigned BANK_SIZE = 64;
    localparam int unsigned NPIX      = IMG_W * IMG_H;
`ifdef IMAGE_WRITER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        abort = 1'b0;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        bank;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic        exp_bank = 1'b0;
    logic [25:0] exp_q[$];
    logic [25:0] mon_e;

    image_frame_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BANK_SIZE(BANK_SIZE), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .bank(bank), .busy(busy), .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write/frame monitor: every write must match the oldest expected pixel.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) begin
                wr_cnt++;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(mon_e[25:8]));
                    check("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
                check("bank_at_done", 32'(bank), 32'(exp_bank));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && guard < 50) begin
            step();
            guard++;
        end
        check("send_ready", 32'(guard < 50), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
    endtask

    // mode 0: pixel k = k[7:0]; mode 1: random pixels with an embedded 0xA5.
    task automatic send_frame(input logic b, input bit gaps, input int mode, input bit bad_csum);
        logic [7:0] cs;
        logic [7:0] d;
        int base;
        cs = 8'h00;
        base = b ? int'(BANK_SIZE) : 0;
        exp_bank = b;
        send(8'hA5);
        if (gaps) gap();
        send({7'($urandom), b});
        for (int k = 0; k < int'(NPIX); k++) begin
            if (mode == 0) d = 8'(k);
            else if (k == 3) d = 8'hA5;
            else d = 8'($urandom);
            exp_q.push_back({18'(base + k), d});
            cs = cs ^ d;
            send(d);
            if (gaps) gap();
        end
`ifdef IMAGE_WRITER_CHECKSUM_EN
        send(bad_csum ? ~cs : cs);
`else
        if (bad_csum) cs = ~cs;
`endif
        step();
    endtask

    initial begin
        int wr0;
        int dn0;
        logic [7:0] d;

        // reset values
        #12;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(s_ready), 32'd0);
        step();
        check("ready_after_release", 32'(s_ready), 32'd1);
        check("idle_not_busy", 32'(busy), 32'd0);

        // bank 0 frame, pixel k = k, continuous
        send_frame(1'b0, 1'b0, 0, 1'b0);
        check("f0_done_cnt", 32'(done_cnt), 32'd1);
        check("f0_wr_cnt", 32'(wr_cnt), 32'(NPIX));
        check("f0_bank", 32'(bank), 32'd0);
        check("f0_busy", 32'(busy), 32'd0);
        check("f0_err", 32'(frame_err), 32'd0);

        // garbage before sync, then bank 1 frame with random gaps
        send(8'h11);
        send(8'h22);
        send(8'h00);
        check("garbage_busy", 32'(busy), 32'd0);
        check("garbage_no_wr", 32'(wr_cnt), 32'(NPIX));
        send_frame(1'b1, 1'b1, 1, 1'b0);
        check("f1_done_cnt", 32'(done_cnt), 32'd2);
        check("f1_wr_cnt", 32'(wr_cnt), 32'(2 * NPIX));
        check("f1_bank", 32'(bank), 32'd1);
        check("f1_err", 32'(frame_err), 32'd0);

        // frame with a wrong checksum byte (ignored when checksum is off)
        send_frame(1'b1, 1'b0, 1, 1'b1);
        check("fbad_done_cnt", 32'(done_cnt), 32'd3);
        check("fbad_err", 32'(frame_err), 32'(CSUM));

        // error flag survives sync, clears on header; then abort at pixel 20
        send(8'hA5);
        check("err_held_in_hdr", 32'(frame_err), 32'(CSUM));
        check("hdr_busy", 32'(busy), 32'd1);
        exp_bank = 1'b0;
        send(8'hAA);
        check("err_cleared_by_hdr", 32'(frame_err), 32'd0);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            exp_q.push_back({18'(k), d});
            send(d);
        end
        s_data  = 8'hEE;
        s_valid = 1'b1;
        abort   = 1'b1;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("abort_wr_cnt", 32'(wr_cnt), 32'(wr0 + 20));
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'(dn0));
        check("abort_err", 32'(frame_err), 32'd0);
        send_frame(1'b0, 1'b0, 1, 1'b0);
        check("after_abort_done", 32'(done_cnt), 32'(dn0 + 1));
        check("after_abort_wr", 32'(wr_cnt), 32'(wr0 + 20 + int'(NPIX)));

        // reset pulsed low in the middle of a frame
        send(8'hA5);
        send(8'h01);
        exp_bank = 1'b1;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            exp_q.push_back({18'(int'(BANK_SIZE) + k), d});
            send(d);
        end
        check("pre_reset_wr_en", 32'(wr_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_bank", 32'(bank), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ready_low", 32'(s_ready), 32'd0);
        step();
        check("rel_ready_high", 32'(s_ready), 32'd1);
        check("mid_rst_wr_cnt", 32'(wr_cnt), 32'(wr0 + 9));
        send_frame(1'b0, 1'b1, 0, 1'b0);
        check("post_rst_done", 32'(done_cnt), 32'(dn0 + 1));
        check("post_rst_wr", 32'(wr_cnt), 32'(wr0 + 9 + int'(NPIX)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_frame_writer.md
# image_frame_writer

Loads images into the shared 320x240 RGB332 image memory from a byte stream, e.g. from a UART receiver. It sits on the write port of the dual-bank image memory. The pixel controller reads the same memory for VGA output. It parses a small header, writes pixels in raster order into bank 0 (base 0) or bank 1 (base BANK_SIZE), and signals frame completion.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per image
- BANK_SIZE, 76800, word offset of bank 1; must be >= IMG_W*IMG_H
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  writer can accept a byte; a transfer occurs when s_valid && s_ready
- abort  in  1  synchronous abort of the current frame
- wr_en  out  1  memory write strobe
- wr_addr  out  18  memory word address
- wr_data  out  8  RGB332 pixel
- bank  out  1  target bank of the current or most recent frame
- busy  out  1  high in HDR, PIX, CHK and DONE
- frame_done  out  1  one-cycle pulse at frame completion
- frame_err  out  1  checksum mismatch flag

## Operation
- Stream format: SYNC_BYTE, bank byte, then IMG_W*IMG_H pixel bytes in raster order (x fastest), then a checksum byte if configured.
- Bank byte: bit0 selects the bank; bits 7:1 are ignored.
- States:
  - IDLE: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE → HDR.
  - HDR: the next accepted byte latches bank, clears addr, x, y, checksum and frame_err → PIX.
  - PIX: each accepted byte produces one write. After byte IMG_W*IMG_H-1 → CHK if configured, else DONE.
  - CHK: next accepted byte compared → DONE.
  - DONE: one cycle, frame_done=1 → IDLE.
- Address: wr_addr = (bank ? BANK_SIZE : 0) + y*IMG_W + x. It is generated by an incrementing 18-bit counter, with no multiplier. x wraps at IMG_W-1 to 0 and increments y. The last pixel is detected by x==IMG_W-1 && y==IMG_H-1.
- abort has priority over everything:
  - The next state is IDLE and the byte accepted in the same cycle is dropped (no write).
  - A write already registered from the previous cycle still completes.
  - No frame_done is produced; frame_err is unchanged.
- A new SYNC_BYTE is only recognised in IDLE. In PIX, 0xA5 is ordinary pixel data.
- Memory contents written before an abort are not restored.

## Timing
- Reset values:
  - s_ready=0 while reset is low; 1 on the first clk edge after release (IDLE).
  - wr_en=0, wr_addr=0, wr_data=0, bank=0, busy=0, frame_done=0, frame_err=0.
  - State is IDLE.
- Write latency:
  - A pixel accepted at edge N gives wr_en=1 with its wr_addr/wr_data registered in cycle N+1.
  - wr_en is high for exactly one cycle per pixel.
- s_ready is 1 in IDLE, HDR, PIX and CHK, and 0 in DONE. Full rate is one byte per cycle; s_valid gaps of any length are tolerated.
- Without checksum: the write of the final pixel and frame_done=1 occur in the same cycle (DONE).
- With checksum: frame_done and the updated frame_err appear in the cycle after the checksum byte is accepted.
- Reset asserted mid-frame: all outputs are forced to reset values immediately (asynchronously). No further writes occur.

## Configuration
- IMAGE_WRITER_CHECKSUM_EN defined:
  - CHK state is present.
  - A running XOR of all pixel bytes is compared with the trailing byte.
  - frame_err=1 on mismatch and stays set until the next HDR byte is accepted.
- Not defined:
  - No CHK state and no trailing byte; PIX goes directly to DONE.
  - frame_err is constant 0.

## Test plan
- Bank 0 frame, bytes 0xA5 0x00 then pixel k = k[7:0], continuous valid:
  - Exactly 76800 writes, addresses 0..76799, data matches.
  - One frame_done, bank=0.
- Bank 1 frame with random s_valid gaps: writes land at addresses 76800..153599, in order, with none missing or duplicated.
- Garbage bytes 0x11, 0x22, 0x00 before 0xA5 0x01: no writes or state change until the sync byte; the first pixel then goes to address 76800.
- abort asserted together with pixel 1000: last write is pixel 999 at its address and there is no frame_done. A fresh 0xA5 0x00 frame restarts at address 0 and completes normally.
- IMAGE_WRITER_CHECKSUM_EN, 4x3 image (IMG_W=4, IMG_H=3, BANK_SIZE=12):
  - Correct XOR byte → frame_done with frame_err=0.
  - Wrong byte → frame_err=1, which clears when the next header byte is accepted.
- reset pulsed low mid-PIX: wr_en, busy and s_ready drop to 0 immediately. After release, s_ready=1 in IDLE and a new frame loads from address 0.
